// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between instruction
// fetch (IF) and the data cache (DC); each access runs IDLE -> BUSY -> DONE.
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 4
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             ifetch_req,
   input  logic [31:0]      ifetch_addr,
   output logic             ifetch_done,
   output logic [31:0]      ifetch_rdata,
   input  logic             dc_req,
   input  logic             dc_we,
   input  logic [31:0]      dc_addr,
   input  logic [31:0]      dc_wdata,
   output logic             dc_done,
   output logic [31:0]      dc_rdata,
   output logic [31:0]      mem_addr,
   output logic [0:3][7:0]  mem_data_in,
   input  logic [0:3][7:0]  mem_data_out,
   output logic             mem_write_en,
   output logic             busy,
   output logic             owner
);

   localparam int CW = $clog2(MEM_LATENCY + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   cnt;
   logic            last_owner;
   logic            owner_q;
   logic            we_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [31:0]     if_rdata_q;
   logic [31:0]     dc_rdata_q;
   logic            grant;
   logic            grant_dc;
   logic            last_beat;
   logic [31:0]     mem_word;

   // On a tie the requester that did not own the previous access wins.
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_dc   = 1'b0;
      last_beat  = 1'b0;
      case (state)
         IDLE: begin
            if (ifetch_req || dc_req) begin
               grant      = 1'b1;
               grant_dc   = dc_req && (!ifetch_req || !last_owner);
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (cnt == LAST_CNT) begin
               last_beat  = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state      <= IDLE;
         cnt        <= '0;
         last_owner <= 1'b0;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dc_rdata_q <= '0;
      end else begin
         state <= state_next;
         if (grant) begin
            owner_q <= grant_dc;
            addr_q  <= grant_dc ? dc_addr : ifetch_addr;
            we_q    <= grant_dc && dc_we;
            wdata_q <= grant_dc ? dc_wdata : 32'd0;
            cnt     <= '0;
         end else if (state == BUSY) begin
            cnt <= cnt + CW'(1);
         end
         if (last_beat && !we_q) begin
            if (owner_q) dc_rdata_q <= mem_word;
            else         if_rdata_q <= mem_word;
         end
         if (state == DONE) last_owner <= owner_q;
      end
   end

   // Memory byte lane k maps to data byte k in both directions.
   always_comb begin
      mem_word = '0;
      for (int k = 0; k < 4; k++) begin
         mem_data_in[k]     = wdata_q[8*k +: 8];
         mem_word[8*k +: 8] = mem_data_out[k];
      end
   end

   // Strobes are masked by reset so an aborted access never writes or completes.
   assign mem_write_en = last_beat && we_q && !rst_b;
   assign ifetch_done  = (state == DONE) && !owner_q && !rst_b;
   assign dc_done      = (state == DONE) &&  owner_q && !rst_b;
   assign busy         = (state != IDLE);
   assign owner        = owner_q;
   assign mem_addr     = addr_q;
   assign ifetch_rdata = if_rdata_q;
   assign dc_rdata     = dc_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with MEM_LATENCY = 4.
module tb_mem_port_arbiter;

   logic            clk = 1'b0;
   logic            rst_b;
   logic            ifetch_req;
   logic [31:0]     ifetch_addr;
   logic            ifetch_done;
   logic [31:0]     ifetch_rdata;
   logic            dc_req;
   logic            dc_we;
   logic [31:0]     dc_addr;
   logic [31:0]     dc_wdata;
   logic            dc_done;
   logic [31:0]     dc_rdata;
   logic [31:0]     mem_addr;
   logic [0:3][7:0] mem_data_in;
   logic [0:3][7:0] mem_data_out;
   logic            mem_write_en;
   logic            busy;
   logic            owner;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.MEM_LATENCY(4)) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .ifetch_req   (ifetch_req),
      .ifetch_addr  (ifetch_addr),
      .ifetch_done  (ifetch_done),
      .ifetch_rdata (ifetch_rdata),
      .dc_req       (dc_req),
      .dc_we        (dc_we),
      .dc_addr      (dc_addr),
      .dc_wdata     (dc_wdata),
      .dc_done      (dc_done),
      .dc_rdata     (dc_rdata),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .mem_write_en (mem_write_en),
      .busy         (busy),
      .owner        (owner)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs and samples both sit 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                                input logic d_req, input logic d_we,
                                input logic [31:0] d_addr, input logic [31:0] d_wdata);
      ifetch_req  = i_req;
      ifetch_addr = i_addr;
      dc_req      = d_req;
      dc_we       = d_we;
      dc_addr     = d_addr;
      dc_wdata    = d_wdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_b        = 1'b1;
      mem_data_out = '0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset state
      tick();
      tick();
      checkOutput("rst_busy",     {31'd0, busy},         32'd0);
      checkOutput("rst_owner",    {31'd0, owner},        32'd0);
      checkOutput("rst_if_done",  {31'd0, ifetch_done},  32'd0);
      checkOutput("rst_dc_done",  {31'd0, dc_done},      32'd0);
      checkOutput("rst_wen",      {31'd0, mem_write_en}, 32'd0);
      checkOutput("rst_addr",     mem_addr,              32'd0);
      checkOutput("rst_wdata",    mem_data_in,           32'd0);
      checkOutput("rst_if_rdata", ifetch_rdata,          32'd0);
      checkOutput("rst_dc_rdata", dc_rdata,              32'd0);
      rst_b = 1'b0;

      // Test 1: IF read of 0x100
      $display("[TB] test 1: IF read");
      mem_data_out = {8'h13, 8'h05, 8'h00, 8'h00};
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int c = 1; c <= 5; c++) begin
         tick();
         checkOutput($sformatf("t1_if_done_c%0d", c), {31'd0, ifetch_done}, {31'd0, c == 5});
         checkOutput($sformatf("t1_wen_c%0d", c), {31'd0, mem_write_en}, 32'd0);
         checkOutput($sformatf("t1_busy_c%0d", c), {31'd0, busy}, 32'd1);
      end
      checkOutput("t1_if_rdata", ifetch_rdata, 32'h0000_0513);
      checkOutput("t1_addr",     mem_addr,     32'h100);
      checkOutput("t1_owner",    {31'd0, owner}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checkOutput("t1_idle_busy", {31'd0, busy},        32'd0);
      checkOutput("t1_idle_done", {31'd0, ifetch_done}, 32'd0);

      // Test 2: DC write of 0xDEADBEEF to 0x2000
      $display("[TB] test 2: DC write");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF);
      for (int c = 1; c <= 5; c++) begin
         tick();
         checkOutput($sformatf("t2_wen_c%0d", c), {31'd0, mem_write_en}, {31'd0, c == 4});
         checkOutput($sformatf("t2_dc_done_c%0d", c), {31'd0, dc_done}, {31'd0, c == 5});
      end
      checkOutput("t2_addr",     mem_addr,            32'h2000);
      checkOutput("t2_data_in",  mem_data_in,         32'hEFBE_ADDE);
      checkOutput("t2_owner",    {31'd0, owner},      32'd1);
      checkOutput("t2_dc_rdata", dc_rdata,            32'd0);
      checkOutput("t2_if_done",  {31'd0, ifetch_done}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Test 3: simultaneous requests straight after reset
      $display("[TB] test 3: tie after reset");
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      mem_data_out = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0);
      for (int c = 1; c <= 11; c++) begin
         tick();
         if (c == 1) begin
            checkOutput("t3_owner_dc", {31'd0, owner}, 32'd1);
            checkOutput("t3_addr_dc",  mem_addr,       32'h80);
         end
         if (c == 5) begin
            dc_req       = 1'b0;
            mem_data_out = {8'hB1, 8'hB2, 8'hB3, 8'hB4};
         end
         if (c == 7) begin
            checkOutput("t3_owner_if", {31'd0, owner}, 32'd0);
            checkOutput("t3_addr_if",  mem_addr,       32'h40);
         end
         checkOutput($sformatf("t3_dc_done_c%0d", c), {31'd0, dc_done},     {31'd0, c == 5});
         checkOutput($sformatf("t3_if_done_c%0d", c), {31'd0, ifetch_done}, {31'd0, c == 11});
      end
      checkOutput("t3_dc_rdata", dc_rdata,     32'hA4A3_A2A1);
      checkOutput("t3_if_rdata", ifetch_rdata, 32'hB4B3_B2B1);

      // Test 4: both requests held through four accesses
      $display("[TB] test 4: round robin");
      dc_req = 1'b1;
      for (int a = 0; a < 4; a++) begin
         logic exp_dc;
         exp_dc = (a % 2 == 0);
         tick();
         checkOutput($sformatf("t4_idle_a%0d", a), {31'd0, busy}, 32'd0);
         tick();
         checkOutput($sformatf("t4_owner_a%0d", a), {31'd0, owner}, {31'd0, exp_dc});
         repeat (3) tick();
         tick();
         checkOutput($sformatf("t4_dc_done_a%0d", a), {31'd0, dc_done},     {31'd0, exp_dc});
         checkOutput($sformatf("t4_if_done_a%0d", a), {31'd0, ifetch_done}, {31'd0, !exp_dc});
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Test 5: reset while a DC write is in progress
      $display("[TB] test 5: reset mid-access");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'h1234_5678);
      repeat (3) tick();
      checkOutput("t5_busy_before", {31'd0, busy}, 32'd1);
      rst_b  = 1'b1;
      dc_req = 1'b0;
      checkOutput("t5_wen_in_rst", {31'd0, mem_write_en}, 32'd0);
      tick();
      rst_b = 1'b0;
      checkOutput("t5_busy",      {31'd0, busy},    32'd0);
      checkOutput("t5_addr",      mem_addr,         32'd0);
      checkOutput("t5_data_in",   mem_data_in,      32'd0);
      checkOutput("t5_if_rdata",  ifetch_rdata,     32'd0);
      checkOutput("t5_dc_rdata",  dc_rdata,         32'd0);
      checkOutput("t5_owner",     {31'd0, owner},   32'd0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         checkOutput($sformatf("t5_wen_c%0d", c),  {31'd0, mem_write_en}, 32'd0);
         checkOutput($sformatf("t5_done_c%0d", c), {31'd0, dc_done},      32'd0);
      end

      // Test 6: address change and request drop during BUSY
      $display("[TB] test 6: mid-access input changes");
      mem_data_out = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 1) ifetch_addr = 32'h300;
         if (c == 2) ifetch_req  = 1'b0;
         if (c <= 4) checkOutput($sformatf("t6_addr_c%0d", c), mem_addr, 32'h100);
         checkOutput($sformatf("t6_if_done_c%0d", c), {31'd0, ifetch_done}, {31'd0, c == 5});
         checkOutput($sformatf("t6_busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 5});
      end
      checkOutput("t6_if_rdata", ifetch_rdata, 32'hC3C2_C1C0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
